nbit_adder: RTL and testbench

- Parameterised N-bit ripple-carry adder with carry-in and carry-out, plus registered status flags (zero, sign, parity, overflow).
- Used as the add datapath of the ALU: the operand pair and carry-in are summed through a chain of single-bit full adders.
- The result is captured into output registers on the clock edge.

---
 rtl/nbit_adder.sv | 99 +++++++++
 tb/tb_nbit_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nbit_adder.sv
// N-bit ripple-carry adder with registered sum, carry-out and zero/sign/parity/overflow flags.
// Latency 1 cycle, one operation per cycle; no handshake, so there is no backpressure.

module nbit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module nbit_adder #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         zero,
  output logic         sign,
  output logic         parity,
  output logic         overflow
);
  logic [N-1:0] s;
  logic         c_msb_in;
  logic         c_out;

  // Each stage owns its own carry nets so the chain is a set of distinct scalars.
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[i-1].co;
    end
    nbit_adder_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci),
      .s  (s[i]),
      .co (co)
    );
  end

  assign c_msb_in = g_bit[N-1].ci;
  assign c_out    = g_bit[N-1].co;

  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;
  logic         zero_d, zero_q;
  logic         sign_d, sign_q;
  logic         parity_d, parity_q;
  logic         overflow_d, overflow_q;

  always_comb begin
    sum_d      = s;
    cout_d     = c_out;
    zero_d     = ~|s;
    sign_d     = s[N-1];
    parity_d   = ~^s;
    overflow_d = c_out ^ c_msb_in;
  end

  // Reset clears parity too, even though an all-zero sum has even parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
      parity_q   <= parity_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign sign     = sign_q;
  assign parity   = parity_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_nbit_adder.sv
// Self-checking bench for nbit_adder: directed corner vectors plus random back-to-back traffic.
module tb_nbit_adder;
  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         zero;
    logic         sign;
    logic         parity;
    logic         overflow;
  } res_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;
  logic         zero;
  logic         sign;
  logic         parity;
  logic         overflow;

  res_t exp_q[$];
  int   n_checks;
  int   n_fail;

  nbit_adder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .zero     (zero),
    .sign     (sign),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic [N-1:0] s, input logic co, input logic z,
                              input logic sg, input logic p, input logic ov);
    res_t r;
    r.sum = s; r.cout = co; r.zero = z; r.sign = sg; r.parity = p; r.overflow = ov;
    return r;
  endfunction

  // Reference: wide integer add, signed range test for overflow, popcount for parity.
  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    res_t r;
    logic [N:0]          w;
    logic signed [N+1:0] ss;
    int                  ones;
    w  = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    ss = $signed({{2{x[N-1]}}, x}) + $signed({{2{y[N-1]}}, y}) + $signed({{(N+1){1'b0}}, ci});
    ones = 0;
    for (int k = 0; k < N; k++) ones += int'(w[k]);
    r.sum      = w[N-1:0];
    r.cout     = w[N];
    r.zero     = (w[N-1:0] == '0);
    r.sign     = w[N-1];
    r.parity   = (ones % 2 == 0);
    r.overflow = (ss > $signed(18'sd32767)) || (ss < -$signed(18'sd32768));
    return r;
  endfunction

  task automatic drive(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input res_t e);
    @(negedge clk);
    a = x; b = y; cin = ci;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    res_t got, e;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    #3;
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_initial got=%h want=%h", got, res_t'('0));
    end
    @(negedge clk); rst = 1'b0;
    drive(16'h0003, 16'h0004, 1'b0, mk(16'h0007, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_preload got=%h want=%h", got, e);
    end
    // Async assertion mid-cycle must clear outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_async got=%h want=%h", got, res_t'('0));
    end
    a = 16'hFFFF; b = 16'h0001;
    @(posedge clk); #1;
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_held got=%h want=%h", got, res_t'('0));
    end
    @(negedge clk); rst = 1'b0;
    drive(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_release got=%h want=%h", got, e);
    end
  endtask

  task automatic test_directed(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic ci, input res_t want);
    res_t got, e;
    drive(x, y, ci, want);
    @(posedge clk); #1;
    got = {sum, cout, zero, sign, parity, overflow};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard_empty got=%h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++; $display("FAIL %s a=%h b=%h cin=%0d got=%h want=%h", name, x, y, ci, got, e);
      end
    end
  endtask

  task automatic test_mixed_signs();
    test_directed("mixed_signs_1", 16'h0001, 16'hAFCF, 1'b0, mk(16'hAFD0, 0, 0, 1, 0, 0));
    test_directed("mixed_signs_2", 16'hF0FF, 16'h0011, 1'b0, mk(16'hF110, 0, 0, 1, 1, 0));
  endtask

  task automatic test_overflow();
    test_directed("neg_overflow", 16'h8000, 16'h8200, 1'b0, mk(16'h0200, 1, 0, 0, 0, 1));
    test_directed("pos_overflow", 16'h7FFF, 16'h0000, 1'b1, mk(16'h8000, 0, 0, 1, 0, 1));
  endtask

  task automatic test_wrap();
    test_directed("wrap_b", 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 1, 0, 1, 0));
    test_directed("wrap_cin", 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1, 1, 0, 1, 0));
    test_directed("ripple_all", 16'hFFFF, 16'hFFFF, 1'b1, mk(16'hFFFF, 1, 0, 1, 1, 0));
  endtask

  // New operands every cycle; garbage is driven between edges and must never surface.
  task automatic test_back_to_back();
    res_t got, e;
    logic [N-1:0] x, y;
    logic         ci;
    @(negedge clk);
    x = N'($urandom); y = N'($urandom); ci = 1'b0;
    a = x; b = y; cin = ci;
    exp_q.push_back(model(x, y, ci));
    for (int i = 0; i < 101; i++) begin
      @(posedge clk); #1;
      got = {sum, cout, zero, sign, parity, overflow};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL back_to_back[%0d] scoreboard_empty got=%h", i, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, e);
        end
      end
      #1;
      a = N'($urandom); b = N'($urandom); cin = ~cin;
      if (i < 100) begin
        @(negedge clk);
        x = N'($urandom); y = N'($urandom); ci = i[0];
        a = x; b = y; cin = ci;
        exp_q.push_back(model(x, y, ci));
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mixed_signs();
    test_overflow();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
